// File: rtl/exe_stage_pipe_if.sv
// Bus between the ID/EXE register, the execute stage and the MEM stage.
// master = upstream/hazard side driving the stage, slave = the execute stage itself.
interface exe_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 24,
  parameter int REG_W  = 4
);
  logic              in_valid;
  logic [3:0]        EXE_CMD;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic              S;
  logic [DATA_W-1:0] PC_in;
  logic [DATA_W-1:0] Val_Rn;
  logic [DATA_W-1:0] Val_Rm;
  logic              imm;
  logic [11:0]       Shift_operand;
  logic [IMM_W-1:0]  Signed_imm;
  logic              C;
  logic [REG_W-1:0]  Dest;
  logic              freeze;
  logic              flush;

  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] ALU_result;
  logic [DATA_W-1:0] Br_addr;
  logic [DATA_W-1:0] Val_Rm_out;
  logic [3:0]        status;
  logic              status_we;
  logic [REG_W-1:0]  Dest_out;
  logic              WB_EN_out;
  logic              MEM_R_EN_out;
  logic              MEM_W_EN_out;

  modport master (
    output in_valid, EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN, S, PC_in, Val_Rn, Val_Rm, imm,
           Shift_operand, Signed_imm, C, Dest, freeze, flush,
    input  busy, out_valid, ALU_result, Br_addr, Val_Rm_out, status, status_we, Dest_out,
           WB_EN_out, MEM_R_EN_out, MEM_W_EN_out
  );

  modport slave (
    input  in_valid, EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN, S, PC_in, Val_Rn, Val_Rm, imm,
           Shift_operand, Signed_imm, C, Dest, freeze, flush,
    output busy, out_valid, ALU_result, Br_addr, Val_Rm_out, status, status_we, Dest_out,
           WB_EN_out, MEM_R_EN_out, MEM_W_EN_out
  );
endinterface

// File: rtl/exe_stage_pipe.sv
// Execute stage: Val2 shifter, ALU, branch adder, iterative multiplier and EXE/MEM register.
// Optional EXE_MUL_EARLY_TERM_EN: multiplier stops once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | accepting single-cycle ops from ID/EXE
// MUL   | multiplier iterating, busy=1, EXE/MEM holds a bubble
// DONE  | product ready but MEM side frozen; waits for !freeze
module exe_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 24,
  parameter int REG_W    = 4,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  exe_stage_pipe_if.slave  bus
);
  localparam int MUL_CYC = DATA_W / MUL_STEP;
  localparam int CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] br_addr;
    logic [DATA_W-1:0] val_rm;
    logic [3:0]        status;
    logic              status_we;
    logic [REG_W-1:0]  dest;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
  } exe_mem_t;

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [4:0] sh);
    return DATA_W'({x, x} >> sh);
  endfunction

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand, mplier, acc, mul_sum, mul_res;
  logic              mul_last;
  logic [DATA_W-1:0] m_br, m_rm;
  logic [REG_W-1:0]  m_dest;
  logic              m_c, m_s, m_wb, m_mr, m_mw;

  logic [DATA_W-1:0] val2, shifted, br_addr, br_off;
  logic [DATA_W-1:0] alu_res, add_b;
  logic [DATA_W:0]   sum;
  logic              add_cin, is_arith, alu_c, alu_v;
  logic [4:0]        sh_amt;
  exe_mem_t          out_q, single_word, mul_word;

  assign sh_amt = bus.Shift_operand[11:7];

  always_comb begin
    case (bus.Shift_operand[6:5])
      2'b00:   shifted = bus.Val_Rm << sh_amt;
      2'b01:   shifted = bus.Val_Rm >> sh_amt;
      2'b10:   shifted = DATA_W'($signed(bus.Val_Rm) >>> sh_amt);
      default: shifted = ror(bus.Val_Rm, sh_amt);
    endcase
    // Loads/stores use the raw 12-bit offset regardless of imm
    if (bus.MEM_R_EN || bus.MEM_W_EN)
      val2 = {{(DATA_W-12){1'b0}}, bus.Shift_operand};
    else if (bus.imm)
      val2 = ror({{(DATA_W-8){1'b0}}, bus.Shift_operand[7:0]}, {bus.Shift_operand[11:8], 1'b0});
    else
      val2 = shifted;
  end

  assign br_off  = {{(DATA_W-IMM_W){bus.Signed_imm[IMM_W-1]}}, bus.Signed_imm} << 2;
  assign br_addr = bus.PC_in + br_off;

  // Subtraction is done as Rn + ~Val2 + cin so carry comes out as ARM's not-borrow
  always_comb begin
    add_b    = val2;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    case (bus.EXE_CMD)
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin is_arith = 1'b1; add_cin = bus.C; end
      CMD_SUB: begin is_arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; add_b = ~val2; add_cin = bus.C; end
      default: ;
    endcase
    sum = {1'b0, bus.Val_Rn} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    case (bus.EXE_CMD)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = bus.Val_Rn & val2;
      CMD_ORR: alu_res = bus.Val_Rn | val2;
      CMD_EOR: alu_res = bus.Val_Rn ^ val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res = sum[DATA_W-1:0];
      default: alu_res = '0;
    endcase
    alu_c = is_arith ? sum[DATA_W] : bus.C;
    alu_v = is_arith && (bus.Val_Rn[DATA_W-1] == add_b[DATA_W-1])
                     && (sum[DATA_W-1] != bus.Val_Rn[DATA_W-1]);
  end

  always_comb begin
    single_word           = '0;
    single_word.valid     = 1'b1;
    single_word.result    = alu_res;
    single_word.br_addr   = br_addr;
    single_word.val_rm    = bus.Val_Rm;
    single_word.status    = {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};
    single_word.status_we = bus.S;
    single_word.dest      = bus.Dest;
    single_word.wb_en     = bus.WB_EN;
    single_word.mem_r_en  = bus.MEM_R_EN;
    single_word.mem_w_en  = bus.MEM_W_EN;
  end

  assign mul_sum = acc + mcand * {{(DATA_W-MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]};
  assign mul_res = (state == S_DONE) ? acc : mul_sum;

`ifdef EXE_MUL_EARLY_TERM_EN
  assign mul_last = (cnt == '0) || ((mplier >> MUL_STEP) == '0);
`else
  assign mul_last = (cnt == '0);
`endif

  always_comb begin
    mul_word           = '0;
    mul_word.valid     = 1'b1;
    mul_word.result    = mul_res;
    mul_word.br_addr   = m_br;
    mul_word.val_rm    = m_rm;
    mul_word.status    = {mul_res[DATA_W-1], mul_res == '0, m_c, 1'b0};
    mul_word.status_we = m_s;
    mul_word.dest      = m_dest;
    mul_word.wb_en     = m_wb;
    mul_word.mem_r_en  = m_mr;
    mul_word.mem_w_en  = m_mw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      out_q  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      m_br   <= '0;
      m_rm   <= '0;
      m_dest <= '0;
      m_c    <= 1'b0;
      m_s    <= 1'b0;
      m_wb   <= 1'b0;
      m_mr   <= 1'b0;
      m_mw   <= 1'b0;
    end else if (bus.flush) begin
      state <= S_IDLE;
      out_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (!bus.freeze) begin
          out_q <= (bus.in_valid && bus.EXE_CMD != CMD_MUL) ? single_word : '0;
          if (bus.in_valid && bus.EXE_CMD == CMD_MUL) begin
            state  <= S_MUL;
            cnt    <= CNT_W'(MUL_CYC - 1);
            acc    <= '0;
            mcand  <= bus.Val_Rn;
            mplier <= val2;
            m_br   <= br_addr;
            m_rm   <= bus.Val_Rm;
            m_dest <= bus.Dest;
            m_c    <= bus.C;
            m_s    <= bus.S;
            m_wb   <= bus.WB_EN;
            m_mr   <= bus.MEM_R_EN;
            m_mw   <= bus.MEM_W_EN;
          end
        end
        S_MUL: if (mul_last) begin
          if (bus.freeze) begin
            acc   <= mul_sum;
            state <= S_DONE;
          end else begin
            out_q <= mul_word;
            state <= S_IDLE;
          end
        end else if (!bus.freeze) begin
          acc    <= mul_sum;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt - 1'b1;
        end
        S_DONE: if (!bus.freeze) begin
          out_q <= mul_word;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.out_valid    = out_q.valid;
  assign bus.ALU_result   = out_q.result;
  assign bus.Br_addr      = out_q.br_addr;
  assign bus.Val_Rm_out   = out_q.val_rm;
  assign bus.status       = out_q.status;
  assign bus.status_we    = out_q.status_we;
  assign bus.Dest_out     = out_q.dest;
  assign bus.WB_EN_out    = out_q.wb_en;
  assign bus.MEM_R_EN_out = out_q.mem_r_en;
  assign bus.MEM_W_EN_out = out_q.mem_w_en;
endmodule

// File: tb/tb_exe_stage_pipe.sv
// Self-checking bench for exe_stage_pipe: directed cases plus randomized ops against an
// arithmetic reference model (default parameters, DATA_W=32, MUL_STEP=4).
module tb_exe_stage_pipe;
  localparam int MUL_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  exe_stage_pipe_if bus ();
  exe_stage_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [3:0] cmd, input logic [31:0] rn, rm,
                        input logic [11:0] so, input logic immf, input logic s, c, mr, mw, wb,
                        input logic [3:0] dest, input logic [23:0] simm, input logic [31:0] pc);
    bus.in_valid = v;     bus.EXE_CMD = cmd;  bus.Val_Rn = rn;   bus.Val_Rm = rm;
    bus.Shift_operand = so; bus.imm = immf;   bus.S = s;         bus.C = c;
    bus.MEM_R_EN = mr;    bus.MEM_W_EN = mw;  bus.WB_EN = wb;    bus.Dest = dest;
    bus.Signed_imm = simm; bus.PC_in = pc;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int sh);
    longint unsigned v;
    v = x;
    return 32'((v >> sh) | (v << (32 - sh)));
  endfunction

  function automatic logic [31:0] m_val2(input logic [11:0] so, input logic immf,
                                         input logic mem, input logic [31:0] rm);
    int sh;
    if (mem) return {20'd0, so};
    if (immf) return ror32({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    sh = int'(so[11:7]);
    case (so[6:5])
      2'd0:    return 32'(longint'(rm) << sh);
      2'd1:    return rm >> sh;
      2'd2:    return 32'(longint'($signed(rm)) >>> sh);
      default: return ror32(rm, sh);
    endcase
  endfunction

  task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a, b, input logic c,
                       output logic [31:0] r, output logic [3:0] st);
    longint ua, ub, sa, sb, u, s;
    logic cf, vf;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cf = c; vf = 1'b0; u = 0; s = 0;
    case (cmd)
      4'b0001: u = ub;
      4'b1001: u = ~ub;
      4'b0110: u = ua & ub;
      4'b0111: u = ua | ub;
      4'b1000: u = ua ^ ub;
      4'b0010: begin u = ua + ub; s = sa + sb; cf = (u >= 64'sh1_0000_0000); end
      4'b0011: begin u = ua + ub + c; s = sa + sb + c; cf = (u >= 64'sh1_0000_0000); end
      4'b0100: begin u = ua - ub; s = sa - sb; cf = (ua >= ub); end
      4'b0101: begin u = ua - ub - (c ? 0 : 1); s = sa - sb - (c ? 0 : 1);
                     cf = (ua >= ub + (c ? 0 : 1)); end
      default: u = 0;
    endcase
    if (cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101})
      vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r  = u[31:0];
    st = {r[31], r == 32'd0, cf, vf};
  endtask

  function automatic logic [31:0] m_br(input logic [31:0] pc, input logic [23:0] simm);
    return 32'(longint'(pc) + 4 * longint'($signed(simm)));
  endfunction

  function automatic int m_lat(input logic [31:0] mplier);
`ifdef EXE_MUL_EARLY_TERM_EN
    int ch;
    logic [31:0] r;
    ch = 1;
    r  = mplier >> 4;
    while (r != 32'd0) begin ch++; r = r >> 4; end
    return ch + 1;
`else
    return (mplier == mplier) ? MUL_CYC + 1 : 0;
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    bus.freeze = 0; bus.flush = 0;
    rst = 1'b1;
    step(); step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    total++; if ({bus.ALU_result, bus.Br_addr, bus.Val_Rm_out} !== 96'd0)
      $display("FAIL reset_data got=%h/%h/%h exp=0", bus.ALU_result, bus.Br_addr, bus.Val_Rm_out); else passed++;
    total++; if ({bus.status, bus.status_we, bus.Dest_out, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out} !== 12'd0)
      $display("FAIL reset_ctrl got=%h exp=0", {bus.status, bus.status_we, bus.Dest_out}); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu_directed();
    set_op(1, 4'b0010, 32'd5, 32'd7, 12'd0, 0, 1, 0, 0, 0, 1, 4'd3, 24'd0, 32'd0);
    step();
    total++; if (bus.ALU_result !== 32'd12) $display("FAIL add_result got=%h exp=0000000c", bus.ALU_result); else passed++;
    total++; if ({bus.out_valid, bus.status_we, bus.status} !== 6'b11_0000)
      $display("FAIL add_flags got=%b%b%b exp=110000", bus.out_valid, bus.status_we, bus.status); else passed++;
    set_op(1, 4'b0100, 32'd3, 32'd5, 12'd0, 0, 1, 1, 0, 0, 1, 4'd3, 24'd0, 32'd0);
    step();
    total++; if (bus.ALU_result !== 32'hFFFF_FFFE) $display("FAIL sub_result got=%h exp=fffffffe", bus.ALU_result); else passed++;
    total++; if (bus.status !== 4'b1000) $display("FAIL sub_flags got=%b exp=1000", bus.status); else passed++;
    set_op(1, 4'b0011, 32'hFFFF_FFFF, 32'd0, 12'd0, 0, 1, 1, 0, 0, 1, 4'd3, 24'd0, 32'd0);
    step();
    total++; if (bus.ALU_result !== 32'd0) $display("FAIL adc_result got=%h exp=0", bus.ALU_result); else passed++;
    total++; if (bus.status !== 4'b0110) $display("FAIL adc_flags got=%b exp=0110", bus.status); else passed++;
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    step();
  endtask

  task automatic test_branch_ldr();
    set_op(1, 4'b0001, 32'd0, 32'd0, 12'd0, 0, 0, 0, 0, 0, 0, 4'd0, 24'hFF_FFFF, 32'h100);
    step();
    total++; if (bus.Br_addr !== 32'h0000_00FC) $display("FAIL br_addr got=%h exp=000000fc", bus.Br_addr); else passed++;
    set_op(1, 4'b0010, 32'h1000, 32'hDEAD_BEEF, 12'h008, 0, 0, 0, 1, 0, 1, 4'd9, 24'd0, 32'd0);
    step();
    total++; if (bus.ALU_result !== 32'h1008) $display("FAIL ldr_addr got=%h exp=00001008", bus.ALU_result); else passed++;
    total++; if ({bus.MEM_R_EN_out, bus.Dest_out, bus.Val_Rm_out} !== {1'b1, 4'd9, 32'hDEAD_BEEF})
      $display("FAIL ldr_ctrl got=%b/%h/%h exp=1/9/deadbeef", bus.MEM_R_EN_out, bus.Dest_out, bus.Val_Rm_out); else passed++;
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    step();
  endtask

  task automatic test_alu_random();
    logic [3:0] cmds [9] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
    logic [31:0] rn, rm, pc, er, eb, v2;
    logic [11:0] so;
    logic [23:0] simm;
    logic [3:0]  cmd, est, dest;
    logic v, immf, s, c, mr, mw, wb;
    int bad;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      cmd = cmds[$urandom_range(0, 8)];
      rn = rand_word(); rm = rand_word(); pc = $urandom;
      so = 12'($urandom); simm = 24'($urandom); dest = 4'($urandom);
      v = ($urandom_range(0, 7) != 0); immf = 1'($urandom); s = 1'($urandom); c = 1'($urandom);
      mr = ($urandom_range(0, 5) == 0); mw = !mr && ($urandom_range(0, 5) == 0); wb = 1'($urandom);
      set_op(v, cmd, rn, rm, so, immf, s, c, mr, mw, wb, dest, simm, pc);
      v2 = m_val2(so, immf, mr | mw, rm);
      m_alu(cmd, rn, v2, c, er, est);
      eb = m_br(pc, simm);
      step();
      total++;
      if (!v) begin
        if ({bus.out_valid, bus.status_we, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out} !== 5'd0) begin
          $display("FAIL rand_bubble[%0d] got=%b exp=00000", i,
                   {bus.out_valid, bus.status_we, bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out});
          bad++;
        end else passed++;
      end else if (bus.out_valid !== 1'b1 || bus.ALU_result !== er || bus.status !== est ||
                   bus.status_we !== s || bus.Br_addr !== eb || bus.Dest_out !== dest ||
                   bus.Val_Rm_out !== rm || {bus.WB_EN_out, bus.MEM_R_EN_out, bus.MEM_W_EN_out} !== {wb, mr, mw}) begin
        $display("FAIL rand_alu[%0d] cmd=%b got=%h/%b/%h exp=%h/%b/%h", i, cmd,
                 bus.ALU_result, bus.status, bus.Br_addr, er, est, eb);
        bad++;
      end else passed++;
    end
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    step();
  endtask

  // Accepts one MUL, then holds in_valid low while the stage is busy.
  task automatic run_mul(input logic [31:0] a, b, input logic s, c, input string tag);
    logic [31:0] exp_r;
    int lat, edges;
    logic busy_ok;
    exp_r = a * b;
    lat = m_lat(b);
    set_op(1, 4'b1010, a, b, 12'd0, 0, s, c, 0, 0, 1, 4'd5, 24'd1, 32'h40);
    step();
    edges = 1;
    busy_ok = 1'b1;
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      step();
      edges++;
    end
    total++; if (edges !== lat) $display("FAIL %s_latency got=%0d exp=%0d", tag, edges, lat); else passed++;
    total++; if (bus.ALU_result !== exp_r || bus.status !== {exp_r[31], exp_r == 32'd0, c, 1'b0} || bus.status_we !== s)
      $display("FAIL %s_result got=%h/%b exp=%h/%b", tag, bus.ALU_result, bus.status, exp_r,
               {exp_r[31], exp_r == 32'd0, c, 1'b0}); else passed++;
    total++; if (busy_ok !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL %s_busy got=%b/%b exp=1/0", tag, busy_ok, bus.busy); else passed++;
    step();
  endtask

  task automatic test_mul();
    logic [31:0] exp_r;
    int lat, busy_cnt, edges;
    // MUL with the next instruction (ADD 1+2) held in ID/EXE while busy
    lat = m_lat(32'h10);
    set_op(1, 4'b1010, 32'h1234, 32'h10, 12'd0, 0, 1, 0, 0, 0, 1, 4'd2, 24'd0, 32'd0);
    step();
    set_op(1, 4'b0010, 32'd1, 32'd2, 12'd0, 0, 0, 0, 0, 0, 1, 4'd4, 24'd0, 32'd0);
    busy_cnt = 0; edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      step();
      edges++;
    end
    total++; if (busy_cnt !== lat - 1) $display("FAIL mul_busy_cycles got=%0d exp=%0d", busy_cnt, lat - 1); else passed++;
    total++; if (edges !== lat || bus.ALU_result !== 32'h12340)
      $display("FAIL mul_hold_result got=%h@%0d exp=00012340@%0d", bus.ALU_result, edges, lat); else passed++;
    step();
    total++; if (bus.ALU_result !== 32'd3 || bus.Dest_out !== 4'd4)
      $display("FAIL held_add got=%h/%h exp=3/4", bus.ALU_result, bus.Dest_out); else passed++;
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    step();
    run_mul(32'd9, 32'd3, 1, 1, "mul_9x3");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, "mul_max");
    run_mul(32'd77, 32'd0, 1, 0, "mul_zero");
    for (int i = 0; i < 6; i++) begin
      exp_r = $urandom;
      run_mul($urandom, (i % 2 == 0) ? (exp_r >> $urandom_range(0, 31)) : exp_r, 1'($urandom), 1'($urandom), "mul_rand");
    end
  endtask

  task automatic test_flush_freeze();
    logic [31:0] r1;
    int lat, seen;
    // flush during the third MUL cycle
    set_op(1, 4'b1010, 32'd3, 32'hFFFF_FFFF, 12'd0, 0, 1, 0, 0, 0, 1, 4'd1, 24'd0, 32'd0);
    step();
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    step(); step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++; if ({bus.busy, bus.out_valid} !== 2'b00) $display("FAIL flush_mul got=%b exp=00", {bus.busy, bus.out_valid}); else passed++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin step(); if (bus.out_valid === 1'b1) seen++; end
    total++; if (seen !== 0) $display("FAIL flush_no_result got=%0d exp=0", seen); else passed++;

    // freeze raised for the final MUL cycle parks the product in DONE
    lat = m_lat(32'h0000_0FF1);
    set_op(1, 4'b1010, 32'd1000, 32'h0000_0FF1, 12'd0, 0, 1, 0, 0, 0, 1, 4'd6, 24'd0, 32'd0);
    step();
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    for (int i = 0; i < lat - 2; i++) step();
    bus.freeze = 1'b1;
    step(); step(); step();
    total++; if ({bus.busy, bus.out_valid} !== 2'b10) $display("FAIL freeze_done got=%b exp=10", {bus.busy, bus.out_valid}); else passed++;
    bus.freeze = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.ALU_result !== 32'd1000 * 32'h0FF1 || bus.busy !== 1'b0)
      $display("FAIL freeze_release got=%b/%h exp=1/%h", bus.out_valid, bus.ALU_result, 32'd1000 * 32'h0FF1); else passed++;

    // freeze in IDLE holds the EXE/MEM register; flush overrides freeze
    set_op(1, 4'b0010, 32'd40, 32'd2, 12'd0, 0, 0, 0, 0, 0, 1, 4'd7, 24'd0, 32'd0);
    step();
    r1 = bus.ALU_result;
    total++; if (r1 !== 32'd42) $display("FAIL pre_freeze got=%h exp=2a", r1); else passed++;
    set_op(1, 4'b0010, 32'd100, 32'd1, 12'd0, 0, 0, 0, 0, 0, 1, 4'd7, 24'd0, 32'd0);
    bus.freeze = 1'b1;
    step();
    total++; if (bus.ALU_result !== 32'd42 || bus.out_valid !== 1'b1)
      $display("FAIL freeze_hold got=%h/%b exp=2a/1", bus.ALU_result, bus.out_valid); else passed++;
    bus.flush = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_over_freeze got=%b exp=0", bus.out_valid); else passed++;
    bus.freeze = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_drop got=%b exp=0", bus.out_valid); else passed++;
    bus.flush = 1'b0;
    step();
    total++; if (bus.ALU_result !== 32'd101) $display("FAIL post_flush got=%h exp=65", bus.ALU_result); else passed++;
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    step();
  endtask

  task automatic test_rst_mid_mul();
    int seen;
    set_op(1, 4'b0010, 32'd1, 32'd1, 12'd0, 0, 1, 0, 0, 0, 1, 4'd1, 24'd0, 32'd0);
    step();
    set_op(1, 4'b1010, 32'd5, 32'hFFFF_FFFF, 12'd0, 0, 1, 0, 0, 0, 1, 4'd2, 24'd0, 32'd0);
    step();
    set_op(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 24'd0, 0);
    step(); step();
    #3 rst = 1'b1;
    #1;
    total++; if ({bus.busy, bus.out_valid, bus.ALU_result, bus.status, bus.status_we, bus.WB_EN_out} !== 39'd0)
      $display("FAIL rst_mid_mul got=%b/%b/%h exp=0/0/0", bus.busy, bus.out_valid, bus.ALU_result); else passed++;
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin step(); if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++; end
    total++; if (seen !== 0) $display("FAIL rst_no_result got=%0d exp=0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_branch_ldr();
    test_alu_random();
    test_mul();
    test_flush_freeze();
    test_rst_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
